// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction-fetch sequencer: owns the PC, one outstanding imem request,
// drops stale responses after a redirect and hands instructions to decode.
module fetch_seq #(
  parameter int                    word_width = 32,
  parameter logic [word_width-1:0] reset_pc   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  output logic [word_width-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [31:0]           imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [word_width-1:0] redirect_addr,
  output logic                  inst_valid,
  output logic [31:0]           inst_data,
  output logic [word_width-1:0] inst_addr,
  input  logic                  inst_ready,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

  localparam logic [word_width-1:0] align_mask = ~(word_width'(3));

  state_t                state_q, state_d;
  logic [word_width-1:0] pc_q, pc_d;
  logic [31:0]           inst_data_q, inst_data_d;
  logic [word_width-1:0] inst_addr_q, inst_addr_d;
  logic [31:0]           fetch_count_q, fetch_count_d;
  logic [word_width-1:0] target;

  assign target = redirect_addr & align_mask;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_data_d   = inst_data_q;
    inst_addr_d   = inst_addr_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = target;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid && redirect_valid) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (imem_resp_valid) begin
          inst_data_d = imem_resp_data;
          inst_addr_d = pc_q;
          pc_d        = pc_q + word_width'(4);
          state_d     = HOLD;
        end else if (redirect_valid) begin
          pc_d    = target;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        // A redirect kills the held instruction even if decode is ready this cycle.
        if (redirect_valid) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (inst_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_d = target;
        end
        if (imem_resp_valid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= reset_pc;
      inst_data_q   <= '0;
      inst_addr_q   <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_data_q   <= inst_data_d;
      inst_addr_q   <= inst_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req_valid = !reset && (state_q == FETCH) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = !reset && (state_q == HOLD);
  assign inst_data      = inst_data_q;
  assign inst_addr      = inst_addr_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - randomized bench for fetch_seq against a flag-based fetch model
// and a latency-modelled instruction memory.
module tb_fetch_seq;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] fetch_count;

  fetch_seq #(.word_width(32), .reset_pc(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_addr(inst_addr), .inst_ready(inst_ready), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Model: request outstanding / response known stale / instruction held for decode.
  bit          m_out, m_stale, m_hold;
  logic [31:0] m_pc, m_data, m_addr, m_count;
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_data;
  logic [31:0] acc_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_stale = 0; m_hold = 0;
    m_pc = RESET_PC; m_data = '0; m_addr = '0; m_count = '0;
  endtask

  task automatic run_cycle(input logic rst_i, input logic rv_i, input logic [31:0] ra_i,
                           input logic rdy_i, input logic irdy_i, input int lat_i);
    logic        exp_req, accept, deliver;
    logic [31:0] tgt;
    @(negedge clk);
    reset          = rst_i;
    redirect_valid = rv_i;
    redirect_addr  = ra_i;
    inst_ready     = irdy_i;
    imem_req_ready = rdy_i && !mem_pending;
    deliver        = mem_pending && (mem_cnt == 0);
    imem_resp_valid = deliver;
    imem_resp_data  = deliver ? mem_data : $urandom;
    #1;
    exp_req = !rst_i && !m_out && !m_hold && !rv_i;
    check("req_valid", imem_req_valid, exp_req);
    check("req_addr", imem_req_addr, m_pc);
    check("inst_valid", inst_valid, !rst_i && m_hold);
    check("inst_data", inst_data, m_data);
    check("inst_addr", inst_addr, m_addr);
    check("fetch_count", fetch_count, m_count);
    accept = exp_req && imem_req_ready;
    if (accept) acc_q.push_back(m_pc);
    @(posedge clk);
    tgt = {ra_i[31:2], 2'b00};
    if (rst_i) begin
      model_reset();
    end else if (m_hold) begin
      if (rv_i) begin m_pc = tgt; m_hold = 0; end
      else if (irdy_i) begin m_count = m_count + 1; m_hold = 0; end
    end else if (!m_out) begin
      if (rv_i) m_pc = tgt;
      else if (imem_req_ready) m_out = 1;
    end else if (!m_stale) begin
      if (deliver && rv_i) begin m_pc = tgt; m_out = 0; end
      else if (deliver) begin
        m_data = mem_data; m_addr = m_pc; m_pc = m_pc + 4; m_out = 0; m_hold = 1;
      end else if (rv_i) begin m_pc = tgt; m_stale = 1; end
    end else begin
      if (rv_i) m_pc = tgt;
      if (deliver) begin m_out = 0; m_stale = 0; end
    end
    if (deliver) mem_pending = 0;
    else if (mem_pending) mem_cnt--;
    if (accept) begin
      mem_pending = 1; mem_cnt = lat_i; mem_data = $urandom;
    end
  endtask

  initial begin
    int          n;
    logic [31:0] ra;
    reset = 1; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    redirect_valid = 0; redirect_addr = '0; inst_ready = 0;
    mem_pending = 0; mem_cnt = 0; mem_data = '0;
    repeat (2) @(posedge clk);
    model_reset();
    run_cycle(1, 0, 0, 1, 1, 0);
    acc_q.delete();

    // zero-wait memory, decode always ready
    repeat (9) run_cycle(0, 0, 0, 1, 1, 0);
    #1;
    check("seq_req_count", acc_q.size(), 3);
    check("seq_addr0", acc_q[0], 32'h100);
    check("seq_addr1", acc_q[1], 32'h104);
    check("seq_addr2", acc_q[2], 32'h108);
    check("seq_fetch_count", fetch_count, 32'd3);

    // decode stalls 4 cycles
    run_cycle(0, 0, 0, 1, 0, 0);
    run_cycle(0, 0, 0, 1, 0, 0);
    repeat (4) run_cycle(0, 0, 0, 1, 0, 0);
    #1;
    check("stall_count_held", fetch_count, 32'd3);
    check("stall_inst_addr", inst_addr, 32'h10C);
    run_cycle(0, 0, 0, 1, 1, 0);
    #1;
    check("stall_count_after", fetch_count, 32'd4);

    // redirect in WAIT, stale response two cycles later
    run_cycle(0, 0, 0, 1, 1, 2);
    run_cycle(0, 1, 32'h203, 1, 1, 0);
    run_cycle(0, 0, 0, 1, 1, 0);
    run_cycle(0, 0, 0, 1, 1, 0);
    #1;
    check("drain_req_valid", imem_req_valid, 1'b1);
    check("drain_req_addr", imem_req_addr, 32'h200);

    // redirect in HOLD beats the handshake
    run_cycle(0, 0, 0, 1, 1, 0);
    run_cycle(0, 0, 0, 1, 1, 0);
    run_cycle(0, 1, 32'h400, 1, 1, 0);
    #1;
    check("hold_redir_count", fetch_count, 32'd4);
    check("hold_redir_addr", imem_req_addr, 32'h400);

    // PC wrap at the top of the address space
    run_cycle(0, 1, 32'hFFFF_FFFE, 1, 1, 0);
    run_cycle(0, 0, 0, 1, 1, 0);
    run_cycle(0, 0, 0, 1, 1, 0);
    run_cycle(0, 0, 0, 1, 1, 0);
    #1;
    check("wrap_addr", imem_req_addr, 32'h0);
    check("wrap_inst_addr", inst_addr, 32'hFFFF_FFFC);
    check("wrap_count", fetch_count, 32'd5);

    // memory not ready, then reset mid-WAIT with a late response
    n = acc_q.size();
    repeat (5) run_cycle(0, 0, 0, 0, 1, 0);
    #1;
    check("notready_no_accept", acc_q.size(), n);
    run_cycle(0, 0, 0, 1, 1, 3);
    run_cycle(0, 0, 0, 1, 1, 0);
    run_cycle(1, 0, 0, 1, 1, 0);
    #1;
    check("rst_mid_addr", imem_req_addr, RESET_PC);
    run_cycle(0, 0, 0, 1, 1, 0);
    run_cycle(0, 0, 0, 1, 1, 0);
    #1;
    check("late_resp_ignored", inst_valid, 1'b0);
    check("late_resp_addr", imem_req_addr, RESET_PC);
    run_cycle(0, 0, 0, 1, 1, 0);
    #1;
    check("post_rst_accept", acc_q[acc_q.size()-1], RESET_PC);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      run_cycle($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, ra,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
